// File: rtl/axi_rd_mux_nport.sv
// Multi-port AXI read engine: round-robin arbitration of SRAM-like read ports onto one AR
// channel, with per-port outstanding counters and routing of R beats back to the issuing port by rid.
module axi_rd_mux_nport #(
  parameter int NUM_PORTS = 2,
  parameter int MAX_OUTS  = 4,
  parameter int ID_W      = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [2*NUM_PORTS-1:0]    req_size,
  input  logic [32*NUM_PORTS-1:0]   req_addr,
  output logic [NUM_PORTS-1:0]      addr_ok,
  output logic [NUM_PORTS-1:0]      data_ok,
  output logic [32*NUM_PORTS-1:0]   rdata_o,
  output logic [ID_W-1:0]           arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_W-1:0]           rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      err
);

  localparam int CNT_W = $clog2(MAX_OUTS + 1);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTS);

  logic                     arvalid_q, arvalid_d;
  logic [ID_W-1:0]          arid_q, arid_d;
  logic [31:0]              araddr_q, araddr_d;
  logic [2:0]               arsize_q, arsize_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     rready_q, rready_d;
  logic [NUM_PORTS-1:0]     data_ok_q, data_ok_d;
  logic [32*NUM_PORTS-1:0]  rdata_o_q, rdata_o_d;
  logic                     err_q, err_d;
  logic [CNT_W-1:0]         cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]         cnt_d [NUM_PORTS];

  logic [NUM_PORTS-1:0]     eligible;
  logic [NUM_PORTS-1:0]     hit;
  logic                     slot_free;
  logic                     grant_valid;
  logic [PTR_W-1:0]         grant_idx;
  logic [CW-1:0]            cand;
  logic                     accept;
  logic                     r_hs;

  assign slot_free = !arvalid_q || arready;
  assign r_hs      = rvalid && rready_q;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    eligible    = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req[i] && (cnt_q[i] < MAX_CNT);
    end
    // Scan starts one past the last winner and wraps, giving round-robin fairness.
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = {1'b0, rr_ptr_q} + CW'(off);
      if (cand >= CW'(NUM_PORTS)) cand = cand - CW'(NUM_PORTS);
      if (!grant_valid && eligible[cand[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // The reset term keeps addr_ok low while resetn is asserted, matching the other outputs.
  assign accept = resetn && slot_free && grant_valid;

  always_comb begin
    addr_ok = '0;
    if (accept) addr_ok[grant_idx] = 1'b1;
  end

  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      arvalid_d = 1'b1;
      arid_d    = ID_W'(grant_idx);
      araddr_d  = req_addr[32*grant_idx +: 32];
      arsize_d  = {1'b0, req_size[2*grant_idx +: 2]};
      rr_ptr_d  = grant_idx;
    end else if (arready) begin
      arvalid_d = 1'b0;
    end
  end

  always_comb begin
    hit       = '0;
    rdata_o_d = rdata_o_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit[i] = r_hs && (rid == ID_W'(i)) && (cnt_q[i] != '0);
      if (hit[i]) rdata_o_d[32*i +: 32] = rdata;
    end
    data_ok_d = hit;
    err_d     = r_hs && (!(|hit) || (rresp != 2'b00));
    rready_d  = 1'b1;
  end

  // Simultaneous issue and return on one port leave its count unchanged.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((accept && grant_idx == PTR_W'(i)) && !hit[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (hit[i] && !(accept && grant_idx == PTR_W'(i))) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      rr_ptr_q  <= PTR_W'(NUM_PORTS - 1);
      rready_q  <= 1'b0;
      data_ok_q <= '0;
      rdata_o_q <= '0;
      err_q     <= 1'b0;
      // NOTE: the counter array is reset because it is control state, unlike a data RAM.
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      rr_ptr_q  <= rr_ptr_d;
      rready_q  <= rready_d;
      data_ok_q <= data_ok_d;
      rdata_o_q <= rdata_o_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign arvalid = arvalid_q;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = rready_q;
  assign data_ok = data_ok_q;
  assign rdata_o = rdata_o_q;
  assign err     = err_q;

  logic unused_rlast;
  assign unused_rlast = rlast;

endmodule

// File: doc/axi_rd_mux_nport.md
Name: axi_rd_mux_nport

Overview:
- Parametrised read-transaction engine for the SRAM-to-AXI bridge; successor to the single-outstanding inst/data read channel.
- Arbitrates NUM_PORTS SRAM-like read request ports onto one AXI AR channel using round-robin.
- Allows up to MAX_OUTS outstanding reads per port and routes R beats back to the requesting port by rid.
- Sits between the CPU-side SRAM-like ports and the AXI crossbar/master port. Write traffic is handled by a separate AW/W/B block.

Parameters:
- NUM_PORTS, 2, number of SRAM-like read ports; port i uses arid = i. Must satisfy 1 <= NUM_PORTS <= 2^ID_W.
- MAX_OUTS, 4, maximum outstanding reads per port. Must be >= 1; counter width is clog2(MAX_OUTS+1).
- ID_W, 4, AXI id width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_PORTS  per-port read request.
- req_size  in  2*NUM_PORTS  per-port size; port i occupies bits [2i+1:2i]; 0 = byte, 1 = half, 2 = word.
- req_addr  in  32*NUM_PORTS  per-port address; port i occupies bits [32i+31:32i].
- addr_ok  out  NUM_PORTS  request accepted this cycle.
- data_ok  out  NUM_PORTS  one-cycle pulse; read data valid.
- rdata_o  out  32*NUM_PORTS  per-port read data, held until that port's next data_ok.
- arid  out  ID_W
- araddr  out  32
- arlen  out  8
- arsize  out  3
- arburst  out  2
- arlock  out  2
- arcache  out  4
- arprot  out  3
- arvalid  out  1
- arready  in  1
- rid  in  ID_W
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1
- err  out  1  one-cycle pulse: unexpected rid or nonzero rresp.

Behaviour:
- Reset values (asynchronous on resetn low):
  - arvalid = 0, arid = 0, araddr = 0, arsize = 0.
  - rready = 0; it rises to 1 on the first clock edge after reset is released and then stays 1.
  - addr_ok = 0, data_ok = 0, rdata_o = 0, err = 0.
  - All per-port counters = 0; RR pointer = NUM_PORTS-1, so port 0 has first priority.
- Constant AR fields: arlen = 0, arburst = 2'b01, arlock = 0, arcache = 0, arprot = 0.
- AR slot: a single register stage.
  - slot_free = !arvalid || arready.
- Eligibility: port i is eligible when req[i] && cnt[i] < MAX_OUTS.
- Arbitration (combinational, same cycle):
  - Among eligible ports, grant the first found scanning from RR pointer+1, wrapping.
  - addr_ok[grant] = slot_free. All other addr_ok bits = 0.
  - At most one addr_ok bit is high per cycle.
- Accept (addr_ok[g] high at a clock edge):
  - arvalid <= 1.
  - arid <= g, zero-extended to ID_W.
  - araddr <= req_addr slice g.
  - arsize <= {1'b0, req_size slice g}.
  - RR pointer <= g.
  - cnt[g] increments.
- Back-to-back: arready && a new accept in the same cycle reloads the slot; throughput is 1 AR per cycle. arready without a new accept clears arvalid.
- Stability: AR fields do not change while arvalid && !arready.
- R channel:
  - Handshake = rvalid && rready. Every beat has rlast = 1; rlast is ignored.
  - If rid < NUM_PORTS and cnt[rid] > 0:
    - cnt[rid] decrements.
    - Next cycle: data_ok[rid] = 1 for exactly one cycle; rdata_o slice rid <= rdata.
    - Other ports' rdata_o slices hold.
  - If rid >= NUM_PORTS or cnt[rid] == 0: beat dropped; no counter change; err pulses next cycle.
  - rresp != 0 on a valid beat: data is still delivered and err pulses next cycle.
- Counter increment and decrement on the same port in the same cycle: count unchanged.
- Counter full: when cnt[i] == MAX_OUTS, port i is skipped by the arbiter. The grant then goes to the next eligible port, with no bubble.
- Ordering: responses per port return in issue order, since same-id AXI responses are ordered. Across ports, responses may interleave in any order.
- Latency:
  - addr_ok to arvalid: 1 cycle.
  - R handshake to data_ok: 1 cycle.
  - Minimum request-to-data: 3 cycles with zero-wait slave.
- Reset mid-operation: everything clears immediately. Outstanding reads are forgotten and their later R beats raise err.

Test Plan:
- Single read: port 0 req addr 0x1000, size 2; arready = 1; rvalid next cycle with rid = 0, rdata = 0xDEADBEEF.
  -> addr_ok[0] at cycle 0; arvalid/araddr = 0x1000, arsize = 3'b010 at cycle 1; data_ok[0] with rdata_o[31:0] = 0xDEADBEEF at cycle 3.
- Round robin: both ports hold req continuously; arready = 1.
  -> addr_ok alternates 0,1,0,1 across 4 cycles; arid sequence 0,1,0,1.
- Backpressure: arready = 0 for 3 cycles.
  -> arvalid, araddr and arid stay stable; addr_ok = 0 throughout; first new addr_ok on the cycle arready = 1.
- Outstanding limit: MAX_OUTS = 4; port 1 issues 4 reads with no R beats returned.
  -> 5th request gets no addr_ok; port 0 is still granted; an R beat with rid = 1 re-enables port 1 on the next cycle.
- Interleaved return: outstanding reads on ports 0 and 1; R order rid = 1 then rid = 0 with data 0xA5A5A5A5, 0x5A5A5A5A.
  -> data_ok[1] with slice 1 = 0xA5A5A5A5, then data_ok[0] with slice 0 = 0x5A5A5A5A.
- Error paths: R beat with rid = 3 (NUM_PORTS = 2) -> err pulses once, no data_ok. R beat with rresp = 2'b10 -> data_ok and err pulse together. resetn low mid-transaction -> all outputs 0 asynchronously.
